// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad column scanner with full-scan debounce and press/release event generation.
// Latency: events register one cycle after the column-3 sample that completes the stable run.
// Backpressure: none; events are single-cycle pulses and key_code holds until the next press.
module keypad_scan_debounce #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] satir_data,
    output logic [3:0] sutun_en,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_release,
    output logic       key_held,
    output logic       key_err
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_MAX    = CW'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {CLS_NONE, CLS_KEY, CLS_MULTI} cls_kind_t;
    typedef struct packed {
        cls_kind_t  kind;
        logic [3:0] idx;
    } cls_t;
    typedef enum logic {IDLE, HELD} state_t;

    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] dwell;
    logic [1:0]    col;
    logic [15:0]   snapshot, snap_full;
    cls_t          prev_cls, cur_cls;
    logic [CW-1:0] deb_cnt, deb_nxt;
    state_t        state, state_nxt;
    logic          dwell_last, scan_done, stable;
    logic          valid_nxt, release_nxt, err_nxt;
    logic [3:0]    code_nxt;
    logic [4:0]    ones;
    logic [3:0]    hit;

    assign dwell_last = (dwell == DWELL_LAST);
    assign scan_done  = dwell_last && (col == 2'd3);
    assign key_held   = (state == HELD);

    // The column-3 rows join the snapshot in the same cycle it is classified.
    always_comb begin
        snap_full = snapshot;
        snap_full[{col, 2'b00} +: 4] = row_s2;
        ones = 5'd0;
        hit  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap_full[i]) begin
                ones = ones + 5'd1;
                hit  = 4'(i);
            end
        end
        cur_cls.kind = (ones == 5'd0) ? CLS_NONE : (ones == 5'd1) ? CLS_KEY : CLS_MULTI;
        cur_cls.idx  = (ones == 5'd1) ? hit : 4'd0;
    end

    always_comb begin
        if (cur_cls == prev_cls) begin
            deb_nxt = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + CW'(1);
        end else begin
            deb_nxt = CW'(1);
        end
        stable = (deb_nxt == DEB_MAX);
    end

    always_comb begin
        state_nxt   = state;
        valid_nxt   = 1'b0;
        release_nxt = 1'b0;
        code_nxt    = key_code;
        err_nxt     = key_err;
        if (scan_done) begin
            err_nxt = stable && (cur_cls.kind == CLS_MULTI);
            if (stable) begin
                case (state)
                    IDLE: if (cur_cls.kind == CLS_KEY) begin
                        state_nxt = HELD;
                        valid_nxt = 1'b1;
                        code_nxt  = cur_cls.idx;
                    end
                    HELD: if (cur_cls.kind == CLS_NONE) begin
                        state_nxt   = IDLE;
                        release_nxt = 1'b1;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_s1      <= '0;
            row_s2      <= '0;
            dwell       <= '0;
            col         <= 2'd0;
            sutun_en    <= 4'b0001;
            snapshot    <= '0;
            prev_cls    <= '{kind: CLS_NONE, idx: 4'd0};
            deb_cnt     <= '0;
            state       <= IDLE;
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            key_err     <= 1'b0;
        end else begin
            row_s1      <= satir_data;
            row_s2      <= row_s1;
            state       <= state_nxt;
            key_code    <= code_nxt;
            key_valid   <= valid_nxt;
            key_release <= release_nxt;
            key_err     <= err_nxt;
            if (dwell_last) begin
                dwell    <= '0;
                col      <= col + 2'd1;
                sutun_en <= {sutun_en[2:0], sutun_en[3]};
                snapshot <= snap_full;
            end else begin
                dwell <= dwell + DW'(1);
            end
            if (scan_done) begin
                prev_cls <= cur_cls;
                deb_cnt  <= deb_nxt;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Scoreboard bench for keypad_scan_debounce: stimulus queues expected events, a monitor pops them.
// Keys are modelled as row lines that follow the enabled column.
module tb_keypad_scan_debounce;

    localparam int SD   = 4;
    localparam int DB   = 3;
    localparam int SCAN = 4 * SD;
    localparam logic [15:0] K9 = 16'h0200;
    localparam logic [15:0] K4 = 16'h0010;

    typedef struct packed {
        logic       rel;
        logic [3:0] code;
    } evt_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  satir_data;
    logic [3:0]  sutun_en;
    logic [3:0]  key_code;
    logic        key_valid, key_release, key_held, key_err;
    logic [15:0] pressed = 16'h0000;

    int   errors = 0;
    int   checks = 0;
    int   events_seen = 0;
    int   cyc = 0;
    evt_t exp_q[$];
    evt_t mon_e;

    keypad_scan_debounce #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .satir_data (satir_data),
        .sutun_en   (sutun_en),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_release(key_release),
        .key_held   (key_held),
        .key_err    (key_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        satir_data = 4'b0000;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[c*4 + r] && sutun_en[c]) satir_data[r] = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (key_valid || key_release)) begin
            events_seen++;
            checks++;
            if (key_valid && key_release) begin
                errors++;
                $display("FAIL event_overlap: key_valid and key_release both high at cycle %0d", cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got rel=%0b code=%0d, expected no event", key_release, key_code);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.rel !== key_release || mon_e.code !== key_code || key_held !== !mon_e.rel) begin
                    errors++;
                    $display("FAIL event: got rel=%0b code=%0d held=%0b, expected rel=%0b code=%0d held=%0b",
                             key_release, key_code, key_held, mon_e.rel, mon_e.code, !mon_e.rel);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_events(input int target, input int deadline, input string name);
        while (events_seen < target && cyc < deadline) tick();
        check(name, (events_seen >= target), 1);
    endtask

    task automatic wait_err(input logic val, input int deadline, input string name);
        while (key_err !== val && cyc < deadline) tick();
        check(name, key_err, val);
    endtask

    task automatic wait_col(input logic [3:0] col, input string name);
        int n = 0;
        while (sutun_en !== col && n < 2 * SCAN) begin
            tick();
            n++;
        end
        check(name, sutun_en, col);
    endtask

    task automatic push(input logic rel, input logic [3:0] code);
        exp_q.push_back('{rel: rel, code: code});
    endtask

    initial begin
        int n;
        int t0;
        ticks(3);
        check("reset_sutun_en", sutun_en, 4'b0001);
        check("reset_outputs", {key_code, key_valid, key_release, key_held, key_err}, 8'h00);
        reset = 1'b0;
        pressed = K9;

        // Reset while column 2 is enabled and key 9 is down.
        wait_col(4'b0100, "reach_col2");
        reset = 1'b1;
        #1;
        check("midscan_reset_sutun_en", sutun_en, 4'b0001);
        check("midscan_reset_outputs", {key_code, key_valid, key_release, key_held, key_err}, 8'h00);
        ticks(2);
        reset = 1'b0;
        t0 = cyc;
        push(1'b0, 4'd9);
        n = 0;
        while (sutun_en === 4'b0001 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("first_column_length", n, 4);
        tick();

        // Clean press of key 9, stable since reset release.
        wait_events(1, t0 + 3 * SCAN + 6, "press9_latency");
        check("press9_held", key_held, 1'b1);
        check("press9_code", key_code, 4'd9);
        ticks(2 * SCAN);
        check("press9_single", events_seen, 1);

        pressed = 16'h0000;
        push(1'b1, 4'd9);
        wait_events(2, cyc + 4 * SCAN + 6, "release9");
        check("release9_held", key_held, 1'b0);
        check("release9_code", key_code, 4'd9);

        // Bounce: toggle every 10 cycles for 5 scans, then settle pressed.
        push(1'b0, 4'd9);
        for (int i = 0; i < 8; i++) begin
            pressed = (i % 2 == 0) ? K9 : 16'h0000;
            ticks(10);
        end
        pressed = K9;
        wait_events(3, cyc + 3 * SCAN + 6, "bounce_press");
        check("bounce_code", key_code, 4'd9);
        ticks(2 * SCAN);
        check("bounce_single", events_seen, 3);
        pressed = 16'h0000;
        push(1'b1, 4'd9);
        wait_events(4, cyc + 4 * SCAN + 6, "bounce_release");

        // Ghosting from IDLE: keys 0 and 15 together.
        ticks(3 * SCAN);
        pressed = 16'h8001;
        wait_err(1'b1, cyc + 4 * SCAN + 6, "ghost_idle_err");
        check("ghost_idle_held", key_held, 1'b0);
        pressed = 16'h0000;
        wait_err(1'b0, cyc + 2 * SCAN + 6, "ghost_idle_clear");
        ticks(4 * SCAN);
        check("ghost_idle_no_event", events_seen, 4);

        // Ghosting while key 9 is held.
        pressed = K9;
        push(1'b0, 4'd9);
        wait_events(5, cyc + 4 * SCAN + 6, "held_press9");
        pressed = K9 | K4;
        wait_err(1'b1, cyc + 4 * SCAN + 6, "held_ghost_err");
        check("held_ghost_held", key_held, 1'b1);
        pressed = K9;
        wait_err(1'b0, cyc + 2 * SCAN + 6, "held_ghost_clear");
        ticks(4 * SCAN);
        check("held_after_ghost", {key_held, key_code}, {1'b1, 4'd9});

        // A different key while held must not change the code.
        pressed = K4;
        ticks(5 * SCAN);
        check("held_other_key", {key_held, key_code}, {1'b1, 4'd9});
        check("held_other_no_event", events_seen, 5);
        pressed = 16'h0000;
        push(1'b1, 4'd9);
        wait_events(6, cyc + 4 * SCAN + 6, "held_release");

        // Short press: only two scans see key 9.
        ticks(3 * SCAN);
        wait_col(4'b1000, "short_align_col3");
        wait_col(4'b0001, "short_align_col0");
        pressed = K9;
        ticks(2 * SCAN);
        pressed = 16'h0000;
        ticks(5 * SCAN);
        check("short_press_held", key_held, 1'b0);
        check("short_press_no_event", events_seen, 6);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
